// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the execute-stage mult/div controller: FSM encoding,
// ALU op codes, rstatus index, exception codes and the writeback bundle type.
package multdiv_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned ST_W   = 2;

    // FSM state encoding
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_START = 2'd1;
    localparam logic [ST_W-1:0] ST_BUSY  = 2'd2;
    localparam logic [ST_W-1:0] ST_WB    = 2'd3;

    // ALU op codes of the R-type mult/div instructions
    localparam logic [OP_W-1:0] ALU_MULT = 5'b00110;
    localparam logic [OP_W-1:0] ALU_DIV  = 5'b00111;

    localparam int unsigned       TIMEOUT_CYCLES_DEF = 40;
    localparam logic [REG_W-1:0]  RSTATUS_REG_DEF    = 5'd30;
    localparam logic [DATA_W-1:0] MULT_EXC_CODE_DEF  = 32'd4;
    localparam logic [DATA_W-1:0] DIV_EXC_CODE_DEF   = 32'd5;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_bundle_t;

    // Exception code matching the kind of operation that failed
    function automatic logic [DATA_W-1:0] exc_code(
        input logic [OP_W-1:0]   kind,
        input logic [DATA_W-1:0] mult_code,
        input logic [DATA_W-1:0] div_code
    );
        return (kind == ALU_MULT) ? mult_code : div_code;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Pipeline / multdiv-unit / writeback signal bundle seen by multdiv_ctrl.
// master is the controller's view, slave is the surrounding execute stage.
interface multdiv_ctrl_if;
    import multdiv_ctrl_pkg::*;

    logic                  mult_x;
    logic                  div_x;
    logic [REG_W-1:0]      rd_x;
    logic [DATA_W-1:0]     opA_x;
    logic [DATA_W-1:0]     opB_x;
    logic                  flush;

    logic                  md_ctrl_mult;
    logic                  md_ctrl_div;
    logic [DATA_W-1:0]     md_opA;
    logic [DATA_W-1:0]     md_opB;
    logic [DATA_W-1:0]     md_result;
    logic                  md_exception;
    logic                  md_ready;

    logic                  stall;
    logic                  wb_valid;
    logic [REG_W-1:0]      wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  timeout_err;

    modport master (
        input  mult_x, div_x, rd_x, opA_x, opB_x, flush,
        input  md_result, md_exception, md_ready,
        output md_ctrl_mult, md_ctrl_div, md_opA, md_opB,
        output stall, wb_valid, wb_rd, wb_data, timeout_err
    );

    modport slave (
        output mult_x, div_x, rd_x, opA_x, opB_x, flush,
        output md_result, md_exception, md_ready,
        input  md_ctrl_mult, md_ctrl_div, md_opA, md_opB,
        input  stall, wb_valid, wb_rd, wb_data, timeout_err
    );

endinterface

// File: rtl/multdiv_ctrl_md_cycle_counter.sv
// BUSY-cycle counter for the mult/div controller; flags the last cycle
// before the operation is declared timed out.
module md_cycle_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic term_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign term_c = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage controller: sequences the external iterative mult/div unit,
// stalls the pipeline while it runs and emits a one-cycle writeback bundle.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [REG_W-1:0]  RSTATUS_REG    = RSTATUS_REG_DEF,
    parameter logic [DATA_W-1:0] MULT_EXC_CODE  = MULT_EXC_CODE_DEF,
    parameter logic [DATA_W-1:0] DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;

    logic              capture_c;
    logic              start_c;
    logic              done_ok_c;
    logic              done_to_c;
    logic              cnt_clear_c;
    logic              cnt_en_c;
    logic              cnt_term_c;

    logic [OP_W-1:0]   kind_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic              md_mult_q;
    logic              md_div_q;
    logic              wb_pending_q;
    wb_bundle_t        wb_q;
    logic              timeout_q;

    // Reset also gates capture so every output reads 0 while reset is held
    assign capture_c = (bus.mult_x | bus.div_x) & ~bus.flush & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        done_ok_c   = 1'b0;
        done_to_c   = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // md_ready here is a stale result from a flushed op
                if (capture_c) begin
                    start_c = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_clear_c = 1'b1;
                state_d     = bus.flush ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                cnt_en_c = 1'b1;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.md_ready) begin
                    done_ok_c = 1'b1;
                    state_d   = ST_WB;
                end else if (cnt_term_c) begin
                    done_to_c = 1'b1;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    md_cycle_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear_c),
        .en     (cnt_en_c),
        .term_c (cnt_term_c)
    );

    // Operand latch, start pulses and writeback bundle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kind_q       <= '0;
            rd_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            md_mult_q    <= 1'b0;
            md_div_q     <= 1'b0;
            wb_pending_q <= 1'b0;
            wb_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            md_mult_q    <= start_c & bus.mult_x;
            md_div_q     <= start_c & ~bus.mult_x;
            wb_pending_q <= done_ok_c | done_to_c;
            if (start_c) begin
                opa_q  <= bus.opA_x;
                opb_q  <= bus.opB_x;
                rd_q   <= bus.rd_x;
                kind_q <= bus.mult_x ? ALU_MULT : ALU_DIV;
            end
            if (done_ok_c) begin
                if (bus.md_exception) begin
                    wb_q.rd   <= RSTATUS_REG;
                    wb_q.data <= exc_code(kind_q, MULT_EXC_CODE, DIV_EXC_CODE);
                end else begin
                    wb_q.rd   <= rd_q;
                    wb_q.data <= bus.md_result;
                end
            end else if (done_to_c) begin
                wb_q.rd   <= RSTATUS_REG;
                wb_q.data <= exc_code(kind_q, MULT_EXC_CODE, DIV_EXC_CODE);
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall        = ((state_q == ST_IDLE) & capture_c)
                            | (state_q == ST_START)
                            | (state_q == ST_BUSY);
    // A flush during WB squashes the instruction that owns the bundle
    assign bus.wb_valid     = wb_pending_q & ~bus.flush;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_data      = wb_q.data;
    assign bus.md_ctrl_mult = md_mult_q;
    assign bus.md_ctrl_div  = md_div_q;
    assign bus.md_opA       = opa_q;
    assign bus.md_opB       = opb_q;
    assign bus.timeout_err  = timeout_q;

endmodule
